// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// default widths / timeout.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 16;
  localparam int unsigned DATA_W_DEFAULT  = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StIssue  = 2'd2,
    StHalted = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: counts cycles spent waiting for a memory ack and flags the
// cycle on which the wait limit is reached.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expired combinationally on the TIMEOUT-th counted cycle, so the caller can
  // act in that same cycle.
  assign expired = count_en && (cnt_q == CntW'(TIMEOUT - 1));

  // Next count: clear wins, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives an external program counter, issues
// memory fetches, and hands instructions downstream with a valid/ready pair.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_out,
  output logic              pc_rst,
  output logic              pc_load,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       fetch_count,
  output logic              err
);

  state_e state_q, state_d;
  logic   accept;
  logic   wd_clear, wd_count, wd_expired;

  // The PC clears on the same edge that resets this block.
  assign pc_rst = ~reset;

  // Watchdog is held clear outside FETCH, so every FETCH entry starts at zero.
  assign wd_clear = (state_q != StFetch);
  assign wd_count = reset && (state_q == StFetch) && !mem_ack;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  // Next-state and strobe outputs; everything is gated off while in reset.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_addr    = '0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_in       = '0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = pc_out;
        if (mem_ack) begin
          pc_inc  = 1'b1;
          state_d = StIssue;
        end else if (wd_expired) begin
          state_d = StHalted;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          accept = 1'b1;
          // Redirect is taken with acceptance regardless of halt/run.
          if (branch_valid) begin
            pc_load = 1'b1;
            pc_in   = branch_target;
          end
          if (halt)     state_d = StHalted;
          else if (run) state_d = StFetch;
          else          state_d = StIdle;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: state_d = StIdle;
    endcase
    if (!reset) begin
      state_d     = StIdle;
      mem_req     = 1'b0;
      mem_addr    = '0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      pc_in       = '0;
      instr_valid = 1'b0;
      accept      = 1'b0;
    end
  end

  // State, captured instruction, acceptance counter and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_inc) begin
        instr    <= mem_rdata;
        instr_pc <= pc_out;
      end
      if (accept) fetch_count <= fetch_count + 16'd1;
      if (wd_expired) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an external PC and a memory whose
// data is derived from the fetch address.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run, halt;
  logic [15:0] pc;
  logic        pc_rst, pc_load, pc_inc;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid, instr_ready;
  logic [15:0] instr, instr_pc;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic [15:0] fetch_count;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  fetch_sequencer #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .halt          (halt),
    .pc_out        (pc),
    .pc_rst        (pc_rst),
    .pc_load       (pc_load),
    .pc_inc        (pc_inc),
    .pc_in         (pc_in),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .fetch_count   (fetch_count),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program counter.
  always_ff @(posedge clk) begin
    if (pc_rst)       pc <= 16'h0000;
    else if (pc_load) pc <= pc_in;
    else if (pc_inc)  pc <= pc + 16'd1;
  end

  assign mem_rdata = {4'hA, pc[11:0]};

  typedef struct {
    logic        run, halt, ack, rdy, bv;
    logic [15:0] bt;
    logic        req;
    logic [15:0] addr;
    logic        inc, load;
    logic [15:0] pin;
    logic        iv;
    logic [15:0] ins, ipc, cnt;
    logic        er;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic h, logic a, logic y, logic b, logic [15:0] t,
                              logic q, logic [15:0] ad, logic i, logic l, logic [15:0] p,
                              logic v, logic [15:0] n, logic [15:0] ip, logic [15:0] c,
                              logic e);
    vec_t x;
    x.run = r; x.halt = h; x.ack = a; x.rdy = y; x.bv = b; x.bt = t;
    x.req = q; x.addr = ad; x.inc = i; x.load = l; x.pin = p;
    x.iv = v; x.ins = n; x.ipc = ip; x.cnt = c; x.er = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one vector just after the edge, compare before the next edge.
  task automatic apply_vec(input int idx, input vec_t v);
    run = v.run; halt = v.halt; mem_ack = v.ack; instr_ready = v.rdy;
    branch_valid = v.bv; branch_target = v.bt;
    #3;
    n_vec++;
    if (mem_req !== v.req || mem_addr !== v.addr || pc_inc !== v.inc ||
        pc_load !== v.load || pc_in !== v.pin || instr_valid !== v.iv ||
        instr !== v.ins || instr_pc !== v.ipc || fetch_count !== v.cnt ||
        err !== v.er || pc_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL vec%0d: got req=%b addr=%h inc=%b load=%b pin=%h iv=%b ins=%h ipc=%h cnt=%h err=%b rst=%b expected req=%b addr=%h inc=%b load=%b pin=%h iv=%b ins=%h ipc=%h cnt=%h err=%b rst=0",
               idx, mem_req, mem_addr, pc_inc, pc_load, pc_in, instr_valid, instr, instr_pc,
               fetch_count, err, pc_rst, v.req, v.addr, v.inc, v.load, v.pin, v.iv, v.ins,
               v.ipc, v.cnt, v.er);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; halt = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 16'h0000;

    // Main flow: sequential fetch, stall, branch, idle, halt.
    vt.push_back(mk(1,0,0,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h0000,16'h0000,16'd0,0));
    vt.push_back(mk(1,0,1,1,0,16'h0000, 1,16'h0000,1,0,16'h0000, 0,16'h0000,16'h0000,16'd0,0));
    vt.push_back(mk(1,0,0,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA000,16'h0000,16'd0,0));
    vt.push_back(mk(1,0,1,1,0,16'h0000, 1,16'h0001,1,0,16'h0000, 0,16'hA000,16'h0000,16'd1,0));
    vt.push_back(mk(1,0,0,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA001,16'h0001,16'd1,0));
    vt.push_back(mk(1,0,1,1,0,16'h0000, 1,16'h0002,1,0,16'h0000, 0,16'hA001,16'h0001,16'd2,0));
    vt.push_back(mk(1,0,0,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA002,16'h0002,16'd2,0));
    vt.push_back(mk(1,0,0,0,0,16'h0000, 1,16'h0003,0,0,16'h0000, 0,16'hA002,16'h0002,16'd3,0));
    vt.push_back(mk(1,0,1,0,0,16'h0000, 1,16'h0003,1,0,16'h0000, 0,16'hA002,16'h0002,16'd3,0));
    vt.push_back(mk(1,0,0,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA003,16'h0003,16'd3,0));
    vt.push_back(mk(1,0,1,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA003,16'h0003,16'd3,0));
    vt.push_back(mk(1,0,0,0,1,16'h0077, 0,16'h0000,0,0,16'h0000, 1,16'hA003,16'h0003,16'd3,0));
    vt.push_back(mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA003,16'h0003,16'd3,0));
    vt.push_back(mk(1,0,0,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA003,16'h0003,16'd3,0));
    vt.push_back(mk(1,0,0,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA003,16'h0003,16'd3,0));
    vt.push_back(mk(1,0,1,1,1,16'h0099, 1,16'h0004,1,0,16'h0000, 0,16'hA003,16'h0003,16'd4,0));
    vt.push_back(mk(1,0,0,1,1,16'h0040, 0,16'h0000,0,1,16'h0040, 1,16'hA004,16'h0004,16'd4,0));
    vt.push_back(mk(1,0,1,1,0,16'h0000, 1,16'h0040,1,0,16'h0000, 0,16'hA004,16'h0004,16'd5,0));
    vt.push_back(mk(0,0,0,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 1,16'hA040,16'h0040,16'd5,0));
    vt.push_back(mk(0,0,1,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'hA040,16'h0040,16'd6,0));
    vt.push_back(mk(1,0,0,1,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'hA040,16'h0040,16'd6,0));
    vt.push_back(mk(1,0,1,1,0,16'h0000, 1,16'h0041,1,0,16'h0000, 0,16'hA040,16'h0040,16'd6,0));
    vt.push_back(mk(1,1,0,1,1,16'h0100, 0,16'h0000,0,1,16'h0100, 1,16'hA041,16'h0041,16'd6,0));
    vt.push_back(mk(1,0,1,1,1,16'h0200, 0,16'h0000,0,0,16'h0000, 0,16'hA041,16'h0041,16'd7,0));
    vt.push_back(mk(1,0,1,1,1,16'h0200, 0,16'h0000,0,0,16'h0000, 0,16'hA041,16'h0041,16'd7,0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
    #2;
    chk("rst_pc_rst", {31'd0, pc_rst}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_count_err", {15'd0, err, fetch_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) apply_vec(i, vt[i]);

    // Reset while halted, then reset mid-FETCH followed by a stray ack.
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
    #2;
    chk("halt_rst_pc_rst", {31'd0, pc_rst}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1; run = 1'b1;
    #2;
    chk("post_rst_state", {15'd0, err, fetch_count}, 32'd0);
    chk("post_rst_instr", {instr, instr_pc}, 32'd0);
    @(posedge clk);
    #1;
    #2;
    chk("fetch_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
    reset = 1'b0; mem_ack = 1'b1;
    #1;
    chk("midfetch_rst_req", {30'd0, mem_req, pc_inc}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1; run = 1'b0; mem_ack = 1'b1;
    #2;
    chk("stray_ack_out", {29'd0, mem_req, pc_inc, instr_valid}, 32'd0);
    chk("stray_ack_cnt", {instr, fetch_count}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    #2;
    chk("stray_ack_idle", {30'd0, instr_valid, mem_req}, 32'd0);
    chk("stray_ack_instr", {instr, instr_pc}, 32'd0);

    // Fetch timeout: 15 FETCH cycles without ack, then sticky halt.
    run = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      #2;
      chk($sformatf("wd_req%0d", i), {30'd0, mem_req, err}, 32'd2);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("wd_halted%0d", i), {29'd0, mem_req, instr_valid, err}, 32'd1);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("wd_err_cleared", {31'd0, err}, 32'd0);

    // Counter wrap: 65535 acceptances then one more.
    run = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; halt = 1'b0; branch_valid = 1'b0;
    repeat (1 + 2 * 65535) @(posedge clk);
    #2;
    chk("cnt_ffff", {16'd0, fetch_count}, 32'h0000FFFF);
    repeat (2) @(posedge clk);
    #2;
    chk("cnt_wrap", {16'd0, fetch_count}, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
